// File: rtl/fir_capture_pkg.sv
// rtl/fir_capture_pkg.sv - shared types, defaults and round/saturate helper for FIR output blocks
package fir_capture_pkg;

  localparam int ACC_W_DEF      = 58;
  localparam int OUT_W_DEF      = 16;
  localparam int FRAC_SHIFT_DEF = 15;

  // Working width of the helper; callers sign-extend into it and slice the result.
  localparam int RS_W = 128;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_ARM    = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

  typedef struct packed {
    logic            sat;
    logic [RS_W-1:0] val;
  } round_sat_t;

  // Round half-up by 'shift' bits, then clamp to a signed 'out_w'-bit range.
  // The working width is far wider than any accumulator, so the rounding add cannot wrap.
  function automatic round_sat_t round_sat(input logic signed [RS_W-1:0] acc,
                                           input int                     shift,
                                           input int                     out_w);
    logic signed [RS_W-1:0] rnd;
    logic signed [RS_W-1:0] sum;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] max_v;
    logic signed [RS_W-1:0] min_v;
    round_sat_t             res;
    rnd   = (shift > 0) ? (RS_W'(1) <<< (shift - 1)) : '0;
    sum   = acc + rnd;
    r     = sum >>> shift;
    max_v = (RS_W'(1) <<< (out_w - 1)) - RS_W'(1);
    min_v = ~max_v;
    res.sat = (r > max_v) || (r < min_v);
    if (r > max_v) begin
      res.val = max_v;
    end else if (r < min_v) begin
      res.val = min_v;
    end else begin
      res.val = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// rtl/fir_sync_fifo.sv - show-ahead synchronous FIFO with full/empty flags
module fir_sync_fifo
  import fir_capture_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = OUT_W_DEF + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO can still take a write.
  assign push_ok = push_i && (!full_o || pop_ok);
  // Head is forced to zero when empty so the port never shows stale storage.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted writes and reads.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Storage array, no reset needed since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fir_output_capture.sv
// rtl/fir_output_capture.sv - capture, round/saturate and frame FIR accumulator output into a stream FIFO
module fir_output_capture
  import fir_capture_pkg::*;
#(
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_LEN  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ACC_W-1:0] acc_in,
  input  logic             acc_sample_en,
  input  logic             filter_delay,
  input  logic             dsp58_delay,
  output logic [OUT_W-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             sat_flag,
  output logic [15:0]      drop_cnt,
  output logic             busy
);

  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic             capture;
  logic             first_cap;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] cur_idx;
  logic             is_last;
  round_sat_t       rs;
  logic             unused_rs_hi;

  logic             s1_valid_q;
  logic [OUT_W-1:0] s1_data_q;
  logic             s1_last_q;
  logic             sat_flag_q;
  logic [15:0]      drop_cnt_q;

  logic [OUT_W:0]   fifo_rdata;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  // Sequencing: wait for taps, arm, start on the first DSP result; losing taps aborts.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    first_cap = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (filter_delay) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (!filter_delay) begin
          state_d = ST_FILL;
        end else if (dsp58_delay) begin
          state_d   = ST_STREAM;
          capture   = acc_sample_en;
          first_cap = 1'b1;
        end
      end
      ST_STREAM: begin
        if (!filter_delay) state_d = ST_FILL;
        else               capture = acc_sample_en;
      end
      default: state_d = ST_FILL;
    endcase
  end

  assign cur_idx = first_cap ? '0 : frame_cnt_q;
  assign is_last = (cur_idx == LAST_IDX);

  // Frame position advances on every capture, even if the FIFO later drops the sample.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (state_d == ST_FILL) begin
      frame_cnt_d = '0;
    end else if (capture) begin
      frame_cnt_d = is_last ? '0 : cur_idx + CNT_W'(1);
    end
  end

  assign rs = round_sat({{(RS_W - ACC_W){acc_in[ACC_W-1]}}, acc_in}, FRAC_SHIFT, OUT_W);
  assign unused_rs_hi = ^rs.val[RS_W-1:OUT_W];

  // FSM state and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Round/saturate pipeline register plus sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_last_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      s1_valid_q <= capture;
      if (capture) begin
        s1_data_q <= rs.val[OUT_W-1:0];
        s1_last_q <= is_last;
      end
      sat_flag_q <= sat_flag_q | (capture & rs.sat);
    end
  end

  fir_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (s1_valid_q),
    .wdata_i ({s1_last_q, s1_data_q}),
    .pop_i   (m_ready),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A full FIFO only refuses the write when the head is not leaving this cycle.
  assign drop = s1_valid_q && fifo_full && !m_ready;

  // Saturating count of samples lost to back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign m_valid  = !fifo_empty;
  assign m_data   = fifo_rdata[OUT_W-1:0];
  assign m_last   = fifo_rdata[OUT_W];
  assign sat_flag = sat_flag_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != ST_FILL) || !fifo_empty;

endmodule

// File: tb/tb_fir_output_capture.sv
// tb/tb_fir_output_capture.sv - directed self-checking bench for fir_output_capture
module tb_fir_output_capture;

  logic        clk;
  logic        rst_n;
  logic [57:0] acc_in;
  logic        acc_sample_en;
  logic        filter_delay;
  logic        dsp58_delay;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic        sat_flag;
  logic [15:0] drop_cnt;
  logic        busy;

  int tests;
  int failed;

  fir_output_capture dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .acc_in        (acc_in),
    .acc_sample_en (acc_sample_en),
    .filter_delay  (filter_delay),
    .dsp58_delay   (dsp58_delay),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .sat_flag      (sat_flag),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_n = 1'b0;
    acc_in = '0;
    acc_sample_en = 1'b0;
    filter_delay = 1'b0;
    dsp58_delay = 1'b0;
    m_ready = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_m_data", 64'(m_data), 64'h0);
    check("rst_m_valid", 64'(m_valid), 64'h0);
    check("rst_m_last", 64'(m_last), 64'h0);
    check("rst_sat_flag", 64'(sat_flag), 64'h0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);

    // Arm
    rst_n = 1'b1;
    filter_delay = 1'b1;
    tick();
    check("arm_busy", 64'(busy), 64'h1);
    check("arm_m_valid", 64'(m_valid), 64'h0);

    // 49152 -> 2, two-cycle latency
    acc_in = 58'd49152;
    acc_sample_en = 1'b1;
    dsp58_delay = 1'b1;
    tick();
    acc_sample_en = 1'b0;
    dsp58_delay = 1'b0;
    check("lat_n1_valid", 64'(m_valid), 64'h0);
    tick();
    check("lat_n2_valid", 64'(m_valid), 64'h1);
    check("r49152_data", 64'(m_data), 64'd2);
    check("r49152_sat", 64'(sat_flag), 64'h0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("pop1_valid", 64'(m_valid), 64'h0);

    // -16384 -> 0 (half-up)
    acc_in = -58'd16384;
    acc_sample_en = 1'b1;
    tick();
    acc_sample_en = 1'b0;
    tick();
    check("rneg_data", 64'(m_data), 64'h0);
    check("rneg_sat", 64'(sat_flag), 64'h0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // 2^30 -> 7FFF, sat
    acc_in = 58'd1 << 30;
    acc_sample_en = 1'b1;
    tick();
    acc_sample_en = 1'b0;
    tick();
    check("rpos_sat_data", 64'(m_data), 64'h7FFF);
    check("rpos_sat_flag", 64'(sat_flag), 64'h1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;

    // -2^40 -> 8000
    acc_in = -(58'd1 << 40);
    acc_sample_en = 1'b1;
    tick();
    acc_sample_en = 1'b0;
    tick();
    check("rneg_sat_data", 64'(m_data), 64'h8000);
    check("rneg_sat_flag", 64'(sat_flag), 64'h1);
    m_ready = 1'b1;
    tick();
    check("round_drop_cnt", 64'(drop_cnt), 64'h0);

    // Drop to FILL then re-arm
    filter_delay = 1'b0;
    tick();
    check("fill_busy", 64'(busy), 64'h0);
    filter_delay = 1'b1;
    tick();

    // 130-sample stream, m_ready=1
    for (int i = 0; i < 130; i++) begin
      acc_in = 58'(i * 32768);
      acc_sample_en = 1'b1;
      dsp58_delay = (i == 0);
      tick();
      if (i >= 1) begin
        check($sformatf("s130_data_%0d", i - 1), 64'(m_data), 64'(i - 1));
        check($sformatf("s130_last_%0d", i - 1), 64'(m_last), 64'(((i - 1) % 64) == 63));
      end
    end
    acc_sample_en = 1'b0;
    dsp58_delay = 1'b0;
    tick();
    check("s130_data_129", 64'(m_data), 64'd129);
    check("s130_last_129", 64'(m_last), 64'h0);
    tick();
    check("s130_drained", 64'(m_valid), 64'h0);
    check("s130_drop_cnt", 64'(drop_cnt), 64'h0);

    // Overflow: 12 samples into 8-entry FIFO
    m_ready = 1'b0;
    for (int j = 0; j < 12; j++) begin
      acc_in = 58'((200 + j) * 32768);
      acc_sample_en = 1'b1;
      tick();
    end
    acc_sample_en = 1'b0;
    tick();
    check("ovf_valid", 64'(m_valid), 64'h1);
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd4);
    check("ovf_hold_data", 64'(m_data), 64'd200);
    tick();
    check("ovf_stable_data", 64'(m_data), 64'd200);
    m_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      check($sformatf("ovf_pop_%0d", j), 64'(m_data), 64'(200 + j));
      tick();
    end
    check("ovf_empty", 64'(m_valid), 64'h0);

    // Abort at frame index 20
    filter_delay = 1'b0;
    tick();
    filter_delay = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      acc_in = 58'((300 + i) * 32768);
      acc_sample_en = 1'b1;
      dsp58_delay = (i == 0);
      tick();
    end
    dsp58_delay = 1'b0;
    filter_delay = 1'b0;
    acc_in = 58'(999 * 32768);
    tick();
    acc_sample_en = 1'b0;
    check("abort_last_data", 64'(m_data), 64'd319);
    check("abort_last_valid", 64'(m_valid), 64'h1);
    tick();
    check("abort_discard", 64'(m_valid), 64'h0);
    check("abort_busy", 64'(busy), 64'h0);

    // Re-arm: first sample must be frame index 0
    filter_delay = 1'b1;
    tick();
    for (int i = 0; i < 64; i++) begin
      acc_in = 58'((500 + i) * 32768);
      acc_sample_en = 1'b1;
      dsp58_delay = (i == 0);
      tick();
      if (i >= 1) check($sformatf("rearm_last_%0d", i - 1), 64'(m_last), 64'h0);
    end
    acc_sample_en = 1'b0;
    dsp58_delay = 1'b0;
    tick();
    check("rearm_data_63", 64'(m_data), 64'd563);
    check("rearm_last_63", 64'(m_last), 64'h1);
    tick();

    // Reset mid-stream with 5 queued
    m_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      acc_in = 58'((700 + j) * 32768);
      acc_sample_en = 1'b1;
      tick();
    end
    acc_sample_en = 1'b0;
    tick();
    check("pre_rst_valid", 64'(m_valid), 64'h1);
    check("pre_rst_drop", 64'(drop_cnt), 64'd4);
    check("pre_rst_data", 64'(m_data), 64'd700);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(m_valid), 64'h0);
    check("mid_rst_drop", 64'(drop_cnt), 64'h0);
    check("mid_rst_sat", 64'(sat_flag), 64'h0);
    check("mid_rst_busy", 64'(busy), 64'h0);
    check("mid_rst_data", 64'(m_data), 64'h0);
    filter_delay = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 64'(busy), 64'h0);
    check("post_rst_valid", 64'(m_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
